lvds_tx: RTL and testbench

Serializer for the modem's LVDS I/Q transmit path, the counterpart of the receive deserializer. It pulls 32-bit I/Q words from the TX sample FIFO and forces the modem sync patterns into each word. It then shifts each word out MSB-first as 2 bits per clock, which feeds an external DDR SB_IO output driven by the same LVDS clock. On FIFO underflow it keeps the modem stream framed by sending a zero-valued idle word.

---
 rtl/lvds_defs.sv | 22 ++
 rtl/lvds_tx.sv | 131 +++++++++++++
 tb/tb_lvds_tx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/lvds_defs.sv
// lvds_defs: constants and types shared by the LVDS I/Q serializer (lvds_tx) and the
// receive deserializer.
//   WORD_BITS         - width of one I/Q word on the link
//   SYNC_I / SYNC_Q   - sync patterns forced into bits [31:30] and [15:14]
//   IDLE_WORD_DEFAULT - zero-valued framed word sent when the TX FIFO underflows
//   tx_state_e        - serializer state encoding, also exported on o_debug_state
package lvds_defs;

  localparam int unsigned WORD_BITS = 32;

  localparam logic [1:0] SYNC_I = 2'b10;
  localparam logic [1:0] SYNC_Q = 2'b01;

  localparam logic [WORD_BITS-1:0] IDLE_WORD_DEFAULT = 32'h8000_4000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StTx   = 2'd2
  } tx_state_e;

endpackage

// File: rtl/lvds_tx.sv
// lvds_tx: LVDS I/Q transmit serializer.
// Pulls 32-bit I/Q words from the TX sample FIFO, forces the I/Q sync patterns into each
// word and shifts it out MSB-first, two bits per clock, towards an external DDR output
// register. On FIFO underflow a framed idle word is sent instead so the stream stays
// aligned.
// Ports:
//   i_ddr_clk         - LVDS/DDR clock, the only clock
//   i_rst             - synchronous active-high reset
//   i_tx_enable       - level request to stream; only sampled at word boundaries
//   i_fifo_empty      - TX FIFO empty flag
//   o_fifo_pull       - FIFO read strobe; data valid on i_fifo_data the following cycle
//   i_fifo_data       - {I sync, I[12:0], I ctrl, Q sync, Q[12:0], Q ctrl}
//   o_ddr_data        - [1] rising-edge bit (earlier), [0] falling-edge bit
//   o_busy            - serializer not idle
//   o_underflow       - one-cycle pulse per idle word inserted
//   o_underflow_count - saturating count of inserted idle words
//   o_debug_state     - current state encoding
module lvds_tx
  import lvds_defs::*;
#(
  parameter logic [WORD_BITS-1:0] IDLE_WORD = IDLE_WORD_DEFAULT
) (
  input  logic                 i_ddr_clk,
  input  logic                 i_rst,
  input  logic                 i_tx_enable,
  input  logic                 i_fifo_empty,
  output logic                 o_fifo_pull,
  input  logic [WORD_BITS-1:0] i_fifo_data,
  output logic [1:0]           o_ddr_data,
  output logic                 o_busy,
  output logic                 o_underflow,
  output logic [7:0]           o_underflow_count,
  output logic [1:0]           o_debug_state
);

  tx_state_e            state_q;
  logic [WORD_BITS-1:0] sr_q;
  logic [3:0]           cnt_q;
  logic                 pulled_q;
  logic                 cont_q;
  logic                 underflow_q;
  logic [7:0]           uf_count_q;

  logic                 pull;
  logic [WORD_BITS-1:0] fmt_word;

  // Sync bits coming from the FIFO are ignored and replaced by the fixed patterns.
  assign fmt_word = {SYNC_I, i_fifo_data[29:16], SYNC_Q, i_fifo_data[13:0]};

  logic unused_sync;
  assign unused_sync = ^{i_fifo_data[31:30], i_fifo_data[15:14]};

  // Pull only when idle or two cycles before the word boundary, so the next word is on
  // i_fifo_data exactly when the last pair of the current word leaves.
  always_comb begin
    pull = 1'b0;
    if (!i_rst && i_tx_enable && !i_fifo_empty) begin
      case (state_q)
        StIdle:  pull = 1'b1;
        StTx:    pull = (cnt_q == 4'd14);
        default: pull = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_ddr_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      cnt_q       <= 4'd0;
      pulled_q    <= 1'b0;
      cont_q      <= 1'b0;
      underflow_q <= 1'b0;
      uf_count_q  <= 8'd0;
    end else begin
      underflow_q <= 1'b0;
      case (state_q)
        StIdle: begin
          sr_q  <= '0;
          cnt_q <= 4'd0;
          if (pull) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          sr_q    <= fmt_word;
          cnt_q   <= 4'd0;
          state_q <= StTx;
        end
        StTx: begin
          cnt_q <= cnt_q + 4'd1;
          // Enable is only honoured here, so a word in flight always completes.
          if (cnt_q == 4'd14) begin
            pulled_q <= pull;
            cont_q   <= i_tx_enable;
          end
          if (cnt_q != 4'd15) begin
            sr_q <= {sr_q[WORD_BITS-3:0], 2'b00};
          end else if (!cont_q) begin
            sr_q    <= '0;
            cnt_q   <= 4'd0;
            state_q <= StIdle;
          end else if (pulled_q) begin
            sr_q  <= fmt_word;
            cnt_q <= 4'd0;
          end else begin
            sr_q        <= IDLE_WORD;
            cnt_q       <= 4'd0;
            underflow_q <= 1'b1;
            if (uf_count_q != 8'hFF) begin
              uf_count_q <= uf_count_q + 8'd1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          sr_q    <= '0;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  assign o_fifo_pull       = pull;
  assign o_ddr_data        = sr_q[WORD_BITS-1:WORD_BITS-2];
  assign o_busy            = (state_q != StIdle);
  assign o_underflow       = underflow_q;
  assign o_underflow_count = uf_count_q;
  assign o_debug_state     = state_q;

endmodule

// File: tb/tb_lvds_tx.sv
// tb_lvds_tx: self-checking bench for lvds_tx. A queue stands in for the TX FIFO, and a
// word-level reference model (current word, pair index, boundary decisions) predicts
// every output each cycle.
module tb_lvds_tx;

  localparam logic [31:0] IdleWord = 32'h8000_4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        empty;
  logic        pull_o;
  logic [31:0] fdata;
  logic [1:0]  ddr_o;
  logic        busy_o;
  logic        uf_o;
  logic [7:0]  ufc_o;
  logic [1:0]  st_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] fifo_q[$];

  // Reference model: 0 idle, 1 load, 2 transmitting pair m_pos of m_word.
  int          m_st;
  int          m_pos;
  logic [31:0] m_word;
  bit          m_cont;
  bit          m_pulled;
  bit          m_uf;
  int          m_ufc;

  always #5 clk = ~clk;

  lvds_tx dut (
    .i_ddr_clk        (clk),
    .i_rst            (rst),
    .i_tx_enable      (en),
    .i_fifo_empty     (empty),
    .o_fifo_pull      (pull_o),
    .i_fifo_data      (fdata),
    .o_ddr_data       (ddr_o),
    .o_busy           (busy_o),
    .o_underflow      (uf_o),
    .o_underflow_count(ufc_o),
    .o_debug_state    (st_o)
  );

  function automatic logic [31:0] fmt(input logic [31:0] d);
    return (d & 32'h3FFF_3FFF) | 32'h8000_4000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_step(input logic p);
    if (rst) begin
      m_st = 0; m_pos = 0; m_word = '0; m_uf = 0; m_ufc = 0; m_cont = 0; m_pulled = 0;
      return;
    end
    m_uf = 0;
    case (m_st)
      0: if (p) m_st = 1;
      1: begin
        m_word = fmt(fdata);
        m_pos  = 0;
        m_st   = 2;
      end
      default: begin
        if (m_pos == 14) begin
          m_cont   = en;
          m_pulled = p;
        end
        if (m_pos < 15) begin
          m_pos++;
        end else if (!m_cont) begin
          m_st  = 0;
          m_pos = 0;
        end else begin
          m_pos = 0;
          if (m_pulled) begin
            m_word = fmt(fdata);
          end else begin
            m_word = IdleWord;
            m_uf   = 1;
            if (m_ufc < 255) m_ufc++;
          end
        end
      end
    endcase
  endfunction

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    empty = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, advance the model at the edge, then serve the FIFO.
  task automatic tick();
    logic        exp_pull;
    logic        pull_seen;
    logic [31:0] sh;
    logic [1:0]  exp_ddr;
    @(negedge clk);
    exp_pull = !rst && en && !empty && (m_st == 0 || (m_st == 2 && m_pos == 14));
    sh       = m_word >> (30 - 2 * m_pos);
    exp_ddr  = (m_st == 2) ? sh[1:0] : 2'b00;
    chk("ddr_data", {30'b0, ddr_o}, {30'b0, exp_ddr});
    chk("fifo_pull", {31'b0, pull_o}, {31'b0, exp_pull});
    chk("busy", {31'b0, busy_o}, (m_st != 0) ? 32'd1 : 32'd0);
    chk("debug_state", {30'b0, st_o}, m_st);
    chk("underflow", {31'b0, uf_o}, {31'b0, m_uf});
    chk("underflow_count", {24'b0, ufc_o}, m_ufc);
    chk("pull_while_empty", {31'b0, pull_o & empty}, 32'd0);
    pull_seen = pull_o;
    @(posedge clk);
    model_step(exp_pull);
    #1;
    if (pull_seen && fifo_q.size() > 0) fdata = fifo_q.pop_front();
    else fdata = $urandom;
    empty = (fifo_q.size() == 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_pos(input int p, input int budget);
    int k;
    k = 0;
    while (!(m_st == 2 && m_pos == p) && k < budget) begin
      tick();
      k++;
    end
    chk("wait_pos_timeout", (k < budget) ? 32'd0 : 32'd1, 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    empty = 1'b1;
    fdata = '0;
    m_st = 0; m_pos = 0; m_word = '0; m_uf = 0; m_ufc = 0; m_cont = 0; m_pulled = 0;

    // Reset then idle.
    repeat (3) begin
      @(posedge clk);
      model_step(1'b0);
    end
    #1;
    tick();
    rst = 1'b0;
    run(3);
    chk("reset_count", {24'b0, ufc_o}, 32'd0);
    chk("reset_busy", {31'b0, busy_o}, 32'd0);

    // Single all-zero word, then underflow idle words.
    push(32'h0000_0000);
    en = 1'b1;
    run(50);

    // Sync forcing / bit order, then back-to-back words.
    push(32'h7FFF_BFFF);
    for (int i = 0; i < 4; i++) push($urandom);
    run(100);

    // Randomised traffic with occasional enable toggles.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) push($urandom);
      if ($urandom_range(0, 63) == 0) en = ~en;
      tick();
    end

    // Underflow saturation.
    en = 1'b1;
    fifo_q.delete();
    empty = 1'b1;
    run(300 * 16 + 40);
    chk("saturated_count", {24'b0, ufc_o}, 32'd255);

    // Graceful stop mid-word; FIFO still has data but no further pulls are allowed.
    push($urandom);
    push($urandom);
    push($urandom);
    wait_pos(5, 40);
    en = 1'b0;
    run(30);
    chk("stop_busy", {31'b0, busy_o}, 32'd0);
    chk("stop_ddr", {30'b0, ddr_o}, 32'd0);

    // Mid-word reset and clean restart.
    en = 1'b1;
    wait_pos(7, 60);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_reset_ddr", {30'b0, ddr_o}, 32'd0);
    chk("mid_reset_count", {24'b0, ufc_o}, 32'd0);
    chk("mid_reset_state", {30'b0, st_o}, 32'd0);
    if (fifo_q.size() == 0) push($urandom);
    run(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
